// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and constants for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLA  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  // Truncated to WIDTH at the point of use.
  localparam logic [63:0] DIV0_RESULT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle for WIDTH cycles.
// quotient_c/remainder_c show the values after the step taken on the next edge.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last_c,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // One restoring step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    shifted     = {rem, quo[WIDTH-1]};
    fits        = (shifted >= {1'b0, dvs});
    remainder_c = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    quotient_c  = {quo[WIDTH-2:0], fits};
    last_c      = busy && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem <= remainder_c;
      quo <= quotient_c;
      cnt <= cnt + CW'(1);
      if (last_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, iterative divide and registered flags.
// Optional macro ALU_MUL_EN enables opcode 1100 as a shift-add unsigned multiply.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             error_flag
);

  state_e           state;
  logic [3:0]       op_q;
  logic             accept_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic             err_c;
  logic             multi_c;
  logic [WIDTH:0]   sum_c;
  logic [SHW-1:0]   shamt_c;
  logic             big_shift_c;
  logic             div_last_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
  logic [WIDTH-1:0] busy_res_c;
  logic             busy_carry_c;

  // Ready in IDLE, or in DONE when the current result is being consumed.
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept_c = in_valid && in_ready;

  // Single-cycle datapath; multi_c marks ops that need the iterative engine.
  always_comb begin
    res_c       = '0;
    carry_c     = 1'b0;
    ovf_c       = 1'b0;
    err_c       = 1'b0;
    multi_c     = 1'b0;
    sum_c       = '0;
    shamt_c     = op2[SHW-1:0];
    big_shift_c = |op2[WIDTH-1:SHW];
    case (operation)
      OP_AND: res_c = op1 & op2;
      OP_OR:  res_c = op1 | op2;
      OP_XOR: res_c = op1 ^ op2;
      OP_NOT: res_c = ~op1;
      OP_SLL, OP_SLA: res_c = big_shift_c ? '0 : (op1 << shamt_c);
      OP_SRL: res_c = big_shift_c ? '0 : (op1 >> shamt_c);
      OP_SRA: res_c = big_shift_c ? {WIDTH{op1[WIDTH-1]}}
                                  : $unsigned($signed(op1) >>> shamt_c);
      OP_ADD: begin
        sum_c   = {1'b0, op1} + {1'b0, op2};
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_c[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        sum_c   = {1'b0, op1} - {1'b0, op2};
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (op1[WIDTH-1] != op2[WIDTH-1]) && (sum_c[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_DIVU, OP_REMU: begin
        if (op2 == '0) begin
          res_c = WIDTH'(DIV0_RESULT);
          err_c = 1'b1;
        end else begin
          multi_c = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: multi_c = 1'b1;
`endif
      default: err_c = 1'b1;
    endcase
  end

  seq_alu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept_c && multi_c),
    .dividend    (op1),
    .divisor     (op2),
    .last_c      (div_last_c),
    .quotient_c  (quo_c),
    .remainder_c (rem_c)
  );

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step_c;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     psum_c;

  // Shift-add multiply: the low half starts as the multiplier and drains right.
  always_comb begin
    psum_c      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step_c = {psum_c, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod  <= '0;
      mcand <= '0;
    end else if (accept_c && (operation == OP_MUL)) begin
      prod  <= {{WIDTH{1'b0}}, op2};
      mcand <= op1;
    end else if (state == ST_BUSY) begin
      prod <= prod_step_c;
    end
  end
`endif

  always_comb begin
    busy_res_c   = quo_c;
    busy_carry_c = 1'b0;
    if (op_q == OP_REMU) busy_res_c = rem_c;
`ifdef ALU_MUL_EN
    if (op_q == OP_MUL) begin
      busy_res_c   = prod_step_c[WIDTH-1:0];
      busy_carry_c = |prod_step_c[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      out_valid  <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            op_q <= operation;
            if (multi_c) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
            end else begin
              state      <= ST_DONE;
              out_valid  <= 1'b1;
              result     <= res_c;
              zero_flag  <= (res_c == '0);
              carry_flag <= carry_c;
              ovf_flag   <= ovf_c;
              error_flag <= err_c;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (div_last_c) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            result     <= busy_res_c;
            zero_flag  <= (busy_res_c == '0);
            carry_flag <= busy_carry_c;
            ovf_flag   <= 1'b0;
            error_flag <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed cases plus a randomized
// scoreboard against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   operation = 4'd0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero_flag, carry_flag, ovf_flag, error_flag;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
    int          lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .op1        (op1),
    .op2        (op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .error_flag (error_flag)
  );

  always #5 clk = ~clk;

  // Reference model straight from the opcode table, using integer arithmetic.
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   x;
    int     ua = int'(a);
    int     ub = int'(b);
    int     sa = int'($signed(a));
    int     sb = int'($signed(b));
    longint t;
    x = '0;
    x.lat = 1;
    case (op)
      4'd0: x.res = a & b;
      4'd1: x.res = a | b;
      4'd2: x.res = a ^ b;
      4'd3: x.res = ~a;
      4'd4, 4'd5: x.res = (ub >= 16) ? 16'd0 : 16'(ua << ub);
      4'd6: x.res = (ub >= 16) ? 16'd0 : 16'(ua >> ub);
      4'd7: x.res = 16'(sa >>> ((ub >= 16) ? 15 : ub));
      4'd8: begin
        t = longint'(ua) + longint'(ub);
        x.res = 16'(t);
        x.c = (t > 65535);
        x.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'd9: begin
        x.res = 16'(ua - ub);
        x.c = (ua < ub);
        x.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      4'd10, 4'd11: begin
        if (ub == 0) begin
          x.res = 16'hFFFF;
          x.e = 1'b1;
        end else begin
          x.res = (op == 4'd10) ? 16'(ua / ub) : 16'(ua % ub);
          x.lat = 17;
        end
      end
`ifdef ALU_MUL_EN
      4'd12: begin
        t = longint'(ua) * longint'(ub);
        x.res = 16'(t);
        x.c = (t > 65535);
        x.lat = 17;
      end
`endif
      default: begin
        x.res = 16'd0;
        x.e = 1'b1;
      end
    endcase
    x.z = (x.res == 16'd0);
    return x;
  endfunction

  // Issue one op with out_ready=1 and report what came back; lat counts edges from accept.
  task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [3:0] fl,
                          output int lat, output int stall);
    int w = 0;
    @(posedge clk); #1;
    operation = op; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    stall = 0;
    while (!out_valid && lat < 60) begin
      if (!in_ready) stall++;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    fl = {zero_flag, carry_flag, ovf_flag, error_flag};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result got %h want 0000", result); end
    vectors++;
    if ({zero_flag, carry_flag, ovf_flag, error_flag} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {zero_flag, carry_flag, ovf_flag, error_flag});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [11] = '{4'h8, 4'h9, 4'h9, 4'hA, 4'hB, 4'hA, 4'hF, 4'h7, 4'h6, 4'h0, 4'hC};
    logic [15:0] as  [11] = '{16'h7FFF, 16'h0003, 16'h0005, 16'd100, 16'd100, 16'h1234,
                              16'h5555, 16'h8000, 16'h8000, 16'hF0F0, 16'h0123};
    logic [15:0] bs  [11] = '{16'h0001, 16'h0005, 16'h0005, 16'd7, 16'd7, 16'h0000,
                              16'h1111, 16'd20, 16'd15, 16'h0FF0, 16'h0456};
    logic [15:0] r;
    logic [3:0]  fl;
    int          lat, stall;
    exp_t        x;
    for (int i = 0; i < 11; i++) begin
      drive_op(ops[i], as[i], bs[i], r, fl, lat, stall);
      x = ref_alu(ops[i], as[i], bs[i]);
      vectors++;
      if (r !== x.res) begin
        miscompares++;
        $display("FAIL dir%0d_result op=%h got %h want %h", i, ops[i], r, x.res);
      end
      vectors++;
      if (fl !== {x.z, x.c, x.v, x.e}) begin
        miscompares++;
        $display("FAIL dir%0d_flags op=%h got %b want %b", i, ops[i], fl, {x.z, x.c, x.v, x.e});
      end
      vectors++;
      if (lat !== x.lat) begin
        miscompares++;
        $display("FAIL dir%0d_latency op=%h got %0d want %0d", i, ops[i], lat, x.lat);
      end
      vectors++;
      if (stall !== x.lat - 1) begin
        miscompares++;
        $display("FAIL dir%0d_stall op=%h got %0d want %0d", i, ops[i], stall, x.lat - 1);
      end
    end
  endtask

  // Result must hold and new requests must be refused while the consumer stalls.
  task automatic test_hold();
    logic [15:0] a = 16'($urandom);
    logic [15:0] b = 16'($urandom);
    exp_t        x = ref_alu(4'h8, a, b);
    @(posedge clk); #1;
    operation = 4'h8; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    operation = 4'h2; op1 = 16'($urandom); op2 = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0)) begin
        miscompares++;
        $display("FAIL hold%0d_handshake got valid=%b ready=%b want valid=1 ready=0", i, out_valid, in_ready);
      end
      vectors++;
      if ({result, zero_flag, carry_flag, ovf_flag, error_flag} !== {x.res, x.z, x.c, x.v, x.e}) begin
        miscompares++;
        $display("FAIL hold%0d_result got %h/%b want %h/%b", i, result,
                 {zero_flag, carry_flag, ovf_flag, error_flag}, x.res, {x.z, x.c, x.v, x.e});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release got valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] r;
    logic [3:0]  fl;
    int          lat, stall;
    int          seen = 0;
    @(posedge clk); #1;
    operation = 4'hA; op1 = 16'd1000; op2 = 16'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
      miscompares++;
      $display("FAIL abort_state got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    drive_op(4'h0, 16'hF0F0, 16'h0FF0, r, fl, lat, stall);
    vectors++;
    if (r !== 16'h00F0) begin miscompares++; $display("FAIL abort_then_and got %h want 00f0", r); end
  endtask

  // Random stream with random consumer back-pressure, checked in order via a queue.
  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        x;
    logic [3:0]  op;
    int          sent = 0;
    int          guard = 0;
    logic        acc_prev = 1'b0;
    localparam int N = 300;
    in_valid = 1'b0;
    while ((sent < N || q.size() != 0 || in_valid) && guard < 20000) begin
      @(posedge clk); #1;
      if (acc_prev) in_valid = 1'b0;
      if (!in_valid && sent < N) begin
        op = 4'($urandom_range(0, 15));
        operation = op;
        op1 = 16'($urandom);
        case ($urandom_range(0, 3))
          0: op2 = 16'($urandom_range(0, 20));
          1: op2 = 16'($urandom_range(0, 3));
          default: op2 = 16'($urandom);
        endcase
        in_valid = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_prev = 1'b0;
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious got result %h with nothing outstanding", result);
        end else begin
          x = q.pop_front();
          if ({result, zero_flag, carry_flag, ovf_flag, error_flag} !== {x.res, x.z, x.c, x.v, x.e}) begin
            miscompares++;
            $display("FAIL b2b_result got %h/%b want %h/%b", result,
                     {zero_flag, carry_flag, ovf_flag, error_flag}, x.res, {x.z, x.c, x.v, x.e});
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_alu(operation, op1, op2));
        sent++;
        acc_prev = 1'b1;
      end
      guard++;
    end
    vectors++;
    if (guard >= 20000) begin
      miscompares++;
      $display("FAIL b2b_timeout got %0d sent %0d pending want all drained", sent, q.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor of the 16-bit combinational arithmetic/logical unit.
- Registered result, valid/ready handshake on input and output, iterative unsigned divide/remainder, and well-defined flags (zero, carry, overflow, error) instead of X-propagation.
- Sits between operand fetch and writeback in the core's execute stage; stalls the pipeline via in_ready while a divide is in flight.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), number of shift-amount bits taken from op2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation and operands presented.
- in_ready  out  1  block accepts a transaction when in_valid & in_ready.
- operation  in  4  opcode (encoding in Behaviour).
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand / shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result when out_valid & out_ready.
- result  out  WIDTH  registered result.
- zero_flag  out  1  result == 0.
- carry_flag  out  1  add carry-out / sub borrow; 0 for other ops.
- ovf_flag  out  1  signed overflow for add/sub; 0 otherwise.
- error_flag  out  1  divide-by-zero or illegal opcode.

Behaviour:
- Opcodes:
  - 0000 and, 0001 or, 0010 xor, 0011 not (~op1).
  - 0100 sll, 0101 sla (same as sll), 0110 srl, 0111 sra (sign fill).
  - 1000 add, 1001 sub, 1010 divu (quotient), 1011 remu (remainder).
  - 1100 mul (only with ALU_MUL_EN); all other codes are illegal.
- Shifts: if op2 >= WIDTH, sll/sla/srl give 0 and sra gives all sign bits; otherwise shift by op2[SHW-1:0].
- Add/sub widths: computed at WIDTH+1 bits. carry_flag = bit WIDTH (for sub, 1 means borrow, i.e. op1 < op2 unsigned). ovf_flag uses the standard two's-complement sign rule.
- FSM states:
  - IDLE: in_ready=1. On accept of a single-cycle op (or illegal op, or div/rem with op2==0), register result/flags and go to DONE; out_valid=1 the cycle after accept (latency 1). On accept of div/rem with op2!=0, latch operands and go to BUSY.
  - BUSY: in_ready=0. Restoring divider runs 1 bit/cycle for exactly WIDTH cycles, then DONE; out_valid asserts WIDTH+1 cycles after accept.
  - DONE: out_valid=1; result/flags held stable while out_ready=0.
    - in_ready = out_ready, so back-to-back issue is allowed: a same-cycle accept replaces the output (next state per IDLE rules).
    - out_ready=1 with no new accept returns the block to IDLE.
- Divide by zero: result = all ones, error_flag=1, carry/ovf=0, latency 1.
- Illegal opcode: result = 0, error_flag=1, zero_flag=1, latency 1.
- zero_flag is always computed from the final registered result.
- Reset (rst_n=0 at an edge): state IDLE, out_valid=0, result=0, all flags=0, in_ready=1. Reset during BUSY aborts the divide with no output produced.
- in_valid while in_ready=0 is ignored; the producer must hold its request.

Optional Feature:
- ALU_MUL_EN defined: opcode 1100 is an unsigned multiply returning the low WIDTH bits. It uses shift-add in BUSY for WIDTH cycles, sharing the divider's counter. carry_flag=1 if any high-half bit is nonzero.
- Not defined: 1100 is illegal (error_flag=1, result 0, latency 1).

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams (OP_AND … OP_MUL);
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - the DIV0_RESULT constant (all ones).
- One sub-module, seq_alu_divider: iterative restoring divider with start/done, quotient and remainder, WIDTH-parametrised; the top handles the FSM, single-cycle datapath and flags.

Test Plan:
- WIDTH=16, add 0x7FFF+0x0001, out_ready=1 -> 1 cycle later result 0x8000, ovf=1, carry=0, zero=0.
- sub 0x0003-0x0005 -> result 0xFFFE, carry(borrow)=1, ovf=0. Then sub 5-5 -> result 0, zero=1.
- divu 100/7 -> in_ready=0 for 16 cycles, out_valid at accept+17 with result 14. remu 100/7 -> 2.
- divu 0x1234/0 -> result 0xFFFF, error=1 at accept+1. Opcode 1111 -> result 0, error=1, zero=1.
- sra 0x8000 by 20 -> 0xFFFF; srl 0x8000 by 15 -> 0x0001. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0, no new accept.
- Reset asserted 5 cycles into a divide -> next cycle out_valid=0, in_ready=1. A following and 0xF0F0&0x0FF0 -> 0x00F0.
